// File: rtl/if_id_dump_controller.sv
// if_id_dump_controller: debug-side reader of the IF/ID latch snapshot.
// Issues single-cycle execute pulses in step mode. After each step, or on a
// dump request, it freezes the snapshot word and streams it to the debug UART
// LSB byte first over a valid/ready byte interface. It also tracks EOF.
// Optional build macro DUMP_HEADER_EN: prefix each dump with header byte 8'hA5.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a step or dump request
// STEP    | one-cycle execute pulse to the latch
// CAPTURE | freeze snapshot and EOF flag into shadow registers
// SEND    | stream bytes, advancing only when the transmitter accepts one
// DONE    | one-cycle completion pulse; fold captured EOF into halted
module if_id_dump_controller #(
   parameter int IF_ID_SIZE = 44,
   parameter int NB_BYTE    = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [1:0]            i_pipeline_mode,
   input  logic                  i_step_req,
   input  logic                  i_dump_req,
   input  logic [IF_ID_SIZE-1:0] i_IF_ID_data,
   input  logic                  i_eof_flag,
   output logic                  o_execute_instruct,
   output logic [NB_BYTE-1:0]    o_tx_data,
   output logic                  o_tx_valid,
   input  logic                  i_tx_ready,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_halted
);

   localparam int NB_BYTES = (IF_ID_SIZE + NB_BYTE - 1) / NB_BYTE;
`ifdef DUMP_HEADER_EN
   localparam int NB_TX = NB_BYTES + 1;
   localparam logic [NB_BYTE-1:0] HEADER = NB_BYTE'(8'hA5);
`else
   localparam int NB_TX = NB_BYTES;
`endif
   localparam int IDX_W = (NB_TX > 1) ? $clog2(NB_TX) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_TX - 1);
   localparam logic [1:0] MODE_STEP = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      STEP    = 3'd1,
      CAPTURE = 3'd2,
      SEND    = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t                                state;
   logic [NB_BYTES-1:0][NB_BYTE-1:0]      shadow;
   logic [NB_BYTES*NB_BYTE-1:0]           data_ext;
   logic [IDX_W-1:0]                      index;
   logic                                  eof_cap;
   logic [NB_BYTE-1:0]                    cur_byte;

   // Zero-extend the snapshot so padding bits in the last byte read as 0.
   always_comb begin
      data_ext                 = '0;
      data_ext[IF_ID_SIZE-1:0] = i_IF_ID_data;
   end

   // Select the byte at the current index; the bus is quiet outside SEND.
   always_comb begin
`ifdef DUMP_HEADER_EN
      if (index == '0) cur_byte = HEADER;
      else             cur_byte = shadow[index - 1'b1];
`else
      cur_byte = shadow[index];
`endif
      o_tx_data = o_tx_valid ? cur_byte : '0;
   end

   // Sequencer: state, shadow registers and registered status outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state              <= IDLE;
         shadow             <= '0;
         index              <= '0;
         eof_cap            <= 1'b0;
         o_execute_instruct <= 1'b0;
         o_tx_valid         <= 1'b0;
         o_busy             <= 1'b0;
         o_done             <= 1'b0;
         o_halted           <= 1'b0;
      end else begin
         o_execute_instruct <= 1'b0;
         o_done             <= 1'b0;
         case (state)
            IDLE: begin
               // Step wins over a simultaneous dump; the step dumps anyway.
               if (i_step_req && (i_pipeline_mode == MODE_STEP) && !o_halted) begin
                  state              <= STEP;
                  o_execute_instruct <= 1'b1;
                  o_busy             <= 1'b1;
               end else if (i_dump_req) begin
                  state  <= CAPTURE;
                  o_busy <= 1'b1;
               end
            end
            STEP: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               shadow     <= data_ext;
               eof_cap    <= i_eof_flag;
               index      <= '0;
               state      <= SEND;
               o_tx_valid <= 1'b1;
            end
            SEND: begin
               if (i_tx_ready) begin
                  if (index == LAST_IDX) begin
                     state      <= DONE;
                     o_tx_valid <= 1'b0;
                     o_done     <= 1'b1;
                  end else begin
                     index <= index + 1'b1;
                  end
               end
            end
            DONE: begin
               o_halted <= o_halted | eof_cap;
               state    <= IDLE;
               o_busy   <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               o_tx_valid <= 1'b0;
               o_busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_dump_controller.sv
// Directed testbench for if_id_dump_controller.
// Honours DUMP_HEADER_EN the same way as the design (expects a leading 8'hA5).
module tb_if_id_dump_controller;

`ifdef DUMP_HEADER_EN
   localparam int NTX = 7;
`else
   localparam int NTX = 6;
`endif

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [1:0]  i_pipeline_mode;
   logic        i_step_req;
   logic        i_dump_req;
   logic [43:0] i_IF_ID_data;
   logic        i_eof_flag;
   logic        o_execute_instruct;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready;
   logic        o_busy;
   logic        o_done;
   logic        o_halted;

   int n_assert = 0;
   int n_fail   = 0;

   if_id_dump_controller #(.IF_ID_SIZE(44), .NB_BYTE(8)) dut (
      .i_clk              (i_clk),
      .i_reset            (i_reset),
      .i_pipeline_mode    (i_pipeline_mode),
      .i_step_req         (i_step_req),
      .i_dump_req         (i_dump_req),
      .i_IF_ID_data       (i_IF_ID_data),
      .i_eof_flag         (i_eof_flag),
      .o_execute_instruct (o_execute_instruct),
      .o_tx_data          (o_tx_data),
      .o_tx_valid         (o_tx_valid),
      .i_tx_ready         (i_tx_ready),
      .o_busy             (o_busy),
      .o_done             (o_done),
      .o_halted           (o_halted)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered one cycle into SEND. Checks every byte, an optional stall on
   // byte stall_idx with the latch input disturbed, then DONE and return to IDLE.
   task automatic expect_dump(input logic [43:0] word, input int stall_idx,
                              input int stall_n, input logic [43:0] disturb);
      logic [47:0] ext;
      logic [7:0]  e;
      ext = {4'b0, word};
      for (int k = 0; k < NTX; k++) begin
`ifdef DUMP_HEADER_EN
         if (k == 0) e = 8'hA5;
         else        e = ext[(k-1)*8 +: 8];
`else
         e = ext[k*8 +: 8];
`endif
         if (k == stall_idx) begin
            i_tx_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               chk("stall_valid", 64'(o_tx_valid), 64'd1);
               chk("stall_data", 64'(o_tx_data), 64'(e));
               i_IF_ID_data = disturb;
               tick;
            end
            i_tx_ready = 1'b1;
         end
         chk("tx_valid", 64'(o_tx_valid), 64'd1);
         chk("tx_data", 64'(o_tx_data), 64'(e));
         chk("no_exec_in_send", 64'(o_execute_instruct), 64'd0);
         chk("no_done_in_send", 64'(o_done), 64'd0);
         tick;
      end
      chk("done_pulse", 64'(o_done), 64'd1);
      chk("valid_after_last", 64'(o_tx_valid), 64'd0);
      tick;
      chk("done_single", 64'(o_done), 64'd0);
      chk("idle_after_done", 64'(o_busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_reset         = 1'b1;
      i_pipeline_mode = 2'b01;
      i_step_req      = 1'b0;
      i_dump_req      = 1'b0;
      i_IF_ID_data    = '0;
      i_eof_flag      = 1'b0;
      i_tx_ready      = 1'b1;

      // 1. Reset state
      repeat (3) tick;
      i_reset = 1'b0;
      repeat (5) tick;
      chk("rst_exec",   64'(o_execute_instruct), 64'd0);
      chk("rst_valid",  64'(o_tx_valid), 64'd0);
      chk("rst_data",   64'(o_tx_data), 64'd0);
      chk("rst_busy",   64'(o_busy), 64'd0);
      chk("rst_done",   64'(o_done), 64'd0);
      chk("rst_halted", 64'(o_halted), 64'd0);

      // 2. Plain dump, ready always high; a second dump request while busy is dropped
      i_IF_ID_data = 44'hABC_1234_5678;
      i_dump_req   = 1'b1;
      tick;
      chk("cap_busy",  64'(o_busy), 64'd1);
      chk("cap_valid", 64'(o_tx_valid), 64'd0);
      chk("cap_exec",  64'(o_execute_instruct), 64'd0);
      tick;
      i_dump_req = 1'b0;
      expect_dump(44'hABC_1234_5678, -1, 0, 44'h0);
      tick;
      chk("no_queued_dump", 64'(o_busy), 64'd0);

      // 3. Stall three cycles on byte 2, latch input changed mid-dump
      i_dump_req = 1'b1;
      tick;
      i_dump_req = 1'b0;
      tick;
      expect_dump(44'hABC_1234_5678, 2, 3, 44'h123_4567_89AB);

      // 4. Step mode: one execute pulse then dump of the post-step word
      i_pipeline_mode = 2'b11;
      i_step_req      = 1'b1;
      tick;
      i_step_req = 1'b0;
      chk("step_exec", 64'(o_execute_instruct), 64'd1);
      chk("step_busy", 64'(o_busy), 64'd1);
      i_IF_ID_data = 44'h1F2_E3D4_C5B6;
      tick;
      chk("step_exec_once", 64'(o_execute_instruct), 64'd0);
      chk("step_cap_valid", 64'(o_tx_valid), 64'd0);
      tick;
      expect_dump(44'h1F2_E3D4_C5B6, -1, 0, 44'h0);

      // Step in continuous modes is ignored
      i_pipeline_mode = 2'b01;
      i_step_req      = 1'b1;
      tick;
      i_step_req = 1'b0;
      chk("cont_no_exec", 64'(o_execute_instruct), 64'd0);
      chk("cont_no_busy", 64'(o_busy), 64'd0);
      i_pipeline_mode = 2'b10;
      i_step_req      = 1'b1;
      tick;
      i_step_req = 1'b0;
      chk("mode10_no_busy", 64'(o_busy), 64'd0);
      tick;
      chk("cont_no_valid", 64'(o_tx_valid), 64'd0);

      // Step and dump together: step wins, exactly one dump
      i_pipeline_mode = 2'b11;
      i_step_req      = 1'b1;
      i_dump_req      = 1'b1;
      tick;
      i_step_req = 1'b0;
      i_dump_req = 1'b0;
      chk("both_exec", 64'(o_execute_instruct), 64'd1);
      i_IF_ID_data = 44'h0A0_B0C0_D0E0;
      tick;
      tick;
      expect_dump(44'h0A0_B0C0_D0E0, -1, 0, 44'h0);
      chk("halted_no_eof", 64'(o_halted), 64'd0);

      // 5. Step capturing EOF sets halted; stepping then blocked, dumps allowed
      i_step_req = 1'b1;
      tick;
      i_step_req   = 1'b0;
      i_IF_ID_data = 44'h765_4321_0FED;
      i_eof_flag   = 1'b1;
      tick;
      tick;
      i_eof_flag = 1'b0;
      expect_dump(44'h765_4321_0FED, -1, 0, 44'h0);
      chk("halted_set", 64'(o_halted), 64'd1);
      i_step_req = 1'b1;
      tick;
      i_step_req = 1'b0;
      chk("halted_no_exec", 64'(o_execute_instruct), 64'd0);
      chk("halted_no_busy", 64'(o_busy), 64'd0);
      i_dump_req = 1'b1;
      tick;
      i_dump_req = 1'b0;
      tick;
      expect_dump(44'h765_4321_0FED, -1, 0, 44'h0);
      chk("halted_sticky", 64'(o_halted), 64'd1);

      // 6. Reset mid-SEND aborts; next dump restarts at the first byte
      i_IF_ID_data = 44'hF0E_1D2C_3B4A;
      i_dump_req   = 1'b1;
      tick;
      i_dump_req = 1'b0;
      tick;
      repeat (3) tick;
      chk("mid_send_valid", 64'(o_tx_valid), 64'd1);
      i_reset = 1'b1;
      #1;
      chk("abort_valid",  64'(o_tx_valid), 64'd0);
      chk("abort_data",   64'(o_tx_data), 64'd0);
      chk("abort_busy",   64'(o_busy), 64'd0);
      chk("abort_halted", 64'(o_halted), 64'd0);
      tick;
      i_reset = 1'b0;
      tick;
      i_dump_req = 1'b1;
      tick;
      i_dump_req = 1'b0;
      tick;
      expect_dump(44'hF0E_1D2C_3B4A, -1, 0, 44'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_dump_controller.md
Name: if_id_dump_controller

Overview:
- Debug-side reader of the IF/ID latch snapshot bus (o_IF_ID_data). It drives the latch's step control and serialises captured snapshots to the debug UART transmitter.
- In step mode it issues single-cycle execute pulses on request. After each step, or on an explicit dump request, it captures the snapshot word and streams it LSB byte first over a valid/ready byte interface.
- It tracks end-of-program (EOF) and blocks further stepping once EOF is seen.

Parameters:
- IF_ID_SIZE, 44, width of the snapshot word.
- NB_BYTE, 8, width of the transmit byte.
- NB_BYTES (localparam), ceil(IF_ID_SIZE/NB_BYTE) = 6, bytes per dump.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_pipeline_mode  in  2  2'b01 continuous, 2'b11 step; other codes treated as continuous.
- i_step_req  in  1  single-cycle pulse: execute one instruction (step mode only).
- i_dump_req  in  1  single-cycle pulse: dump the current snapshot without stepping.
- i_IF_ID_data  in  IF_ID_SIZE  snapshot word from the IF/ID latch.
- i_eof_flag  in  1  EOF flag from the IF/ID latch.
- o_execute_instruct  out  1  one-cycle execute pulse to the latch.
- o_tx_data  out  NB_BYTE  byte to the UART transmitter.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  transmitter accepts the byte this cycle.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse after the last byte is accepted.
- o_halted  out  1  sticky, set when a captured EOF flag is 1.

Behaviour:
- Clock i_clk; reset i_reset, asynchronous, active-high.
- Reset state: FSM IDLE; all outputs 0; shadow register 0; byte index 0; o_halted 0. Reset during any state aborts the dump immediately; no partial byte is retained.
- FSM states: IDLE, STEP, CAPTURE, SEND, DONE. All outputs are registered or decoded from state.
- IDLE:
  - i_step_req && mode==2'b11 && !o_halted -> STEP.
  - else i_dump_req -> CAPTURE.
  - If both requests arrive in the same cycle, step wins and the dump request is dropped; the step itself produces a dump.
  - i_step_req in continuous mode, or while halted, is ignored.
- STEP: exactly one cycle, o_execute_instruct=1, then CAPTURE. The latch updates on the edge that ends STEP, so CAPTURE sees the new data.
- CAPTURE: one cycle. shadow <= i_IF_ID_data, eof_cap <= i_eof_flag, index <= 0. Next state SEND.
- SEND:
  - o_tx_valid=1; o_tx_data = shadow[index*8 +: 8]. Bits at or above IF_ID_SIZE in the last byte read as 0 (for 44 bits: byte5 = {4'b0, data[43:40]}).
  - o_tx_data holds stable while o_tx_valid && !i_tx_ready.
  - On valid && ready: if index==NB_BYTES-1 -> DONE, else index+1. One byte per cycle maximum; ready held high yields back-to-back bytes.
- DONE: one cycle, o_done=1; o_halted <= o_halted | eof_cap. Next state IDLE.
- Any i_step_req/i_dump_req arriving while o_busy=1 is dropped; requests are not queued.
- The snapshot is frozen in the shadow register; i_IF_ID_data changes during SEND do not affect the transmitted bytes.
- o_halted clears only on reset. Dumps remain allowed while halted.
- Latency, dump request to first byte valid: 2 cycles (CAPTURE, then SEND). Step request to first byte valid: 3 cycles.

Optional Feature:
- Macro DUMP_HEADER_EN.
- Defined: SEND first transmits header byte 8'hA5 (index 0), then the NB_BYTES data bytes, NB_BYTES+1 bytes in total. The header obeys the same handshake rules.
- Undefined: no header; only the NB_BYTES data bytes are sent.

Test Plan:
1. Assert reset, release, idle 5 cycles -> all outputs 0; o_busy=0; FSM in IDLE.
2. i_IF_ID_data=44'hABC_1234_5678, pulse i_dump_req, i_tx_ready=1 -> bytes 78,56,34,12,BC,0A on consecutive cycles; o_done pulses one cycle after byte 0A; o_execute_instruct stays 0.
3. Same dump with i_tx_ready low 3 cycles on byte 2 -> o_tx_data=34 held stable with o_tx_valid=1 until accepted; byte order unchanged; i_IF_ID_data changed mid-dump has no effect.
4. mode=2'b11, pulse i_step_req -> exactly one o_execute_instruct cycle, then a dump of the post-step word. mode=2'b01, pulse i_step_req -> no pulse, no dump, o_busy=0.
5. Step with i_eof_flag=1 -> o_halted=1 after o_done. A further i_step_req is ignored; i_dump_req still produces 6 bytes.
6. Assert i_reset mid-SEND (after byte 2) -> o_tx_valid=0 immediately, FSM IDLE. A new dump restarts at byte 0. With DUMP_HEADER_EN defined, the first byte is A5 and 7 bytes are sent.
